// File: rtl/lcd_text_driver.sv
// HD44780 16x2 text driver: power-up delay, fixed init commands, then an endless
// two-line refresh built from a per-frame snapshot of both line buffers.
module lcd_text_driver #(
    parameter int POWERUP_CYCLES = 30,
    parameter int CLEAR_CYCLES   = 2
) (
    input  logic         clk_1kHz,
    input  logic         rst,
    input  logic [127:0] i_line1,
    input  logic [127:0] i_line2,
    output logic         o_lcd_e,
    output logic         o_lcd_rs,
    output logic         o_lcd_rw,
    output logic [7:0]   o_lcd_data,
    output logic         o_init_done,
    output logic         o_frame_done
);
    typedef enum logic [1:0] {ST_PWR, ST_INIT, ST_CLRWAIT, ST_FRAME} state_t;
    typedef enum logic [1:0] {PH_S, PH_P, PH_H} phase_t;

    localparam logic [9:0] PWR_LAST = 10'(POWERUP_CYCLES);
    localparam logic [9:0] CLR_LAST = 10'((CLEAR_CYCLES > 0) ? CLEAR_CYCLES - 1 : 0);
    localparam bit         CLR_SKIP = (CLEAR_CYCLES == 0);

    state_t       state_q;
    phase_t       phase_q;
    logic [9:0]   cnt_q;
    logic [3:0]   idx_q;
    logic         line2_q;
    logic         hdr_q;
    logic [127:0] snap1_q;
    logic [127:0] snap2_q;
    logic         e_q;
    logic         rs_q;
    logic [7:0]   data_q;
    logic         init_done_q;
    logic         frame_done_q;

    logic         last_char;
    logic         start_frame;
    logic [127:0] cur_line;

    function automatic logic [7:0] init_cmd(input logic [1:0] n);
        case (n)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Char k sits at bits [127-8k -: 8], i.e. base 8*(15-k) = {~k, 3'b000}.
    function automatic logic [7:0] char_at(input logic [127:0] line, input logic [3:0] k);
        return line[{~k, 3'b000} +: 8];
    endfunction

    always_comb begin
        cur_line    = line2_q ? snap2_q : snap1_q;
        last_char   = line2_q && !hdr_q && (idx_q == 4'd15);
        start_frame = 1'b0;
        if (state_q == ST_INIT && phase_q == PH_H && idx_q == 4'd3 && CLR_SKIP)
            start_frame = 1'b1;
        if (state_q == ST_CLRWAIT && cnt_q == CLR_LAST)
            start_frame = 1'b1;
        if (state_q == ST_FRAME && phase_q == PH_H && last_char)
            start_frame = 1'b1;
    end

    always_ff @(posedge clk_1kHz) begin
        if (rst) begin
            state_q      <= ST_PWR;
            phase_q      <= PH_S;
            cnt_q        <= '0;
            idx_q        <= '0;
            line2_q      <= 1'b0;
            hdr_q        <= 1'b0;
            snap1_q      <= '0;
            snap2_q      <= '0;
            e_q          <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (start_frame) begin
                // Snapshot taken on the same edge that launches the line-1 address command.
                state_q     <= ST_FRAME;
                phase_q     <= PH_S;
                line2_q     <= 1'b0;
                hdr_q       <= 1'b1;
                idx_q       <= '0;
                rs_q        <= 1'b0;
                data_q      <= 8'h80;
                snap1_q     <= i_line1;
                snap2_q     <= i_line2;
                init_done_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_PWR: begin
                        if (cnt_q == PWR_LAST) begin
                            state_q <= ST_INIT;
                            phase_q <= PH_S;
                            idx_q   <= '0;
                            rs_q    <= 1'b0;
                            data_q  <= init_cmd(2'd0);
                        end else begin
                            cnt_q <= cnt_q + 10'd1;
                        end
                    end
                    ST_CLRWAIT: cnt_q <= cnt_q + 10'd1;
                    default: begin
                        case (phase_q)
                            PH_S: begin
                                e_q     <= 1'b1;
                                phase_q <= PH_P;
                            end
                            PH_P: begin
                                e_q          <= 1'b0;
                                phase_q      <= PH_H;
                                frame_done_q <= (state_q == ST_FRAME) && last_char;
                            end
                            default: begin
                                phase_q <= PH_S;
                                if (state_q == ST_INIT) begin
                                    if (idx_q == 4'd3) begin
                                        state_q <= ST_CLRWAIT;
                                        cnt_q   <= '0;
                                    end else begin
                                        idx_q  <= idx_q + 4'd1;
                                        data_q <= init_cmd(idx_q[1:0] + 2'd1);
                                    end
                                end else if (hdr_q) begin
                                    hdr_q  <= 1'b0;
                                    idx_q  <= '0;
                                    rs_q   <= 1'b1;
                                    data_q <= char_at(cur_line, 4'd0);
                                end else if (idx_q == 4'd15) begin
                                    line2_q <= 1'b1;
                                    hdr_q   <= 1'b1;
                                    rs_q    <= 1'b0;
                                    data_q  <= 8'hC0;
                                end else begin
                                    idx_q  <= idx_q + 4'd1;
                                    data_q <= char_at(cur_line, idx_q + 4'd1);
                                end
                            end
                        endcase
                    end
                endcase
            end
        end
    end

    assign o_lcd_e      = e_q;
    assign o_lcd_rs     = rs_q;
    assign o_lcd_rw     = 1'b0;
    assign o_lcd_data   = data_q;
    assign o_init_done  = init_done_q;
    assign o_frame_done = frame_done_q;
endmodule
